// File: rtl/wb_ctl_pipe.sv
// wb_ctl_pipe: decodes issued RV32I instructions into writeback controls and
// carries them through STAGES register stages to the register-file write port.
// Also reports whether a queried source register has a write still in flight.
module wb_ctl_pipe #(
  parameter int STAGES       = 2,     // issue-to-writeback depth, legal 1..4
  parameter bit ILLEGAL_TRAP = 1'b1   // 1: unknown opcodes flag illegal
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_in_valid,
  input  logic [31:0] i_instruction,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [4:0]  i_query_rs1,
  input  logic [4:0]  i_query_rs2,
  output logic        o_out_valid,
  output logic [1:0]  o_wb_sel,
  output logic [4:0]  o_rd,
  output logic        o_reg_we,
  output logic        o_is_load,
  output logic        o_illegal,
  output logic        o_hit_rs1,
  output logic        o_hit_rs2
);

  // RV32I major opcodes
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // writeback source select encodings
  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [1:0] wb_sel;
    logic [4:0] rd;
    logic       we;
    logic       is_load;
    logic       illegal;
  } entry_t;

  // Decode one instruction into a pipeline entry; x0 is never written.
  function automatic entry_t decode(input logic valid, input logic [31:0] instr);
    entry_t e;
    e.valid   = valid;
    e.wb_sel  = WB_MEM;
    e.rd      = instr[11:7];
    e.we      = 1'b0;
    e.is_load = 1'b0;
    e.illegal = 1'b0;
    case (instr[6:0])
      OP_LUI, OP_AUIPC, OP_IMM, OP_REG: begin
        e.wb_sel = WB_ALU;
        e.we     = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        e.wb_sel = WB_PC4;
        e.we     = 1'b1;
      end
      OP_LOAD: begin
        e.wb_sel  = WB_MEM;
        e.we      = 1'b1;
        e.is_load = 1'b1;
      end
      OP_BRANCH, OP_STORE, OP_FENCE, OP_SYSTEM: begin
        e.wb_sel = WB_MEM;
        e.we     = 1'b0;
      end
      default: begin
        e.wb_sel  = WB_MEM;
        e.we      = 1'b0;
        e.illegal = ILLEGAL_TRAP;
      end
    endcase
    e.we = e.we & (e.rd != 5'd0);
    return e;
  endfunction

  entry_t r_pipe [STAGES];
  entry_t w_stage0;
  entry_t w_last;
  logic   w_hit1;
  logic   w_hit2;

  // Decode the presented instruction for capture into stage 0.
  always_comb begin
    w_stage0 = decode(i_in_valid, i_instruction);
  end

  // Pipeline registers: flush clears valids, stall holds, otherwise shift.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_pipe[i] <= '0;
      end
    end else if (i_flush) begin
      // payload fields keep stale values; only valids matter
      for (int i = 0; i < STAGES; i++) begin
        r_pipe[i].valid <= 1'b0;
      end
    end else if (!i_stall) begin
      r_pipe[0] <= w_stage0;
      for (int i = 1; i < STAGES; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  // Writeback port: last stage, with all fields gated to 0 when invalid.
  always_comb begin
    w_last      = r_pipe[STAGES-1];
    o_out_valid = w_last.valid;
    if (w_last.valid) begin
      o_wb_sel  = w_last.wb_sel;
      o_rd      = w_last.rd;
      o_reg_we  = w_last.we;
      o_is_load = w_last.is_load;
      o_illegal = w_last.illegal;
    end else begin
      o_wb_sel  = 2'b00;
      o_rd      = 5'd0;
      o_reg_we  = 1'b0;
      o_is_load = 1'b0;
      o_illegal = 1'b0;
    end
  end

  // Scoreboard: any valid in-flight write to a queried non-zero register.
  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      w_hit1 = w_hit1 | (r_pipe[i].valid & r_pipe[i].we & (r_pipe[i].rd == i_query_rs1));
      w_hit2 = w_hit2 | (r_pipe[i].valid & r_pipe[i].we & (r_pipe[i].rd == i_query_rs2));
    end
    o_hit_rs1 = w_hit1 & (i_query_rs1 != 5'd0);
    o_hit_rs2 = w_hit2 & (i_query_rs2 != 5'd0);
  end

endmodule

// File: doc/wb_ctl_pipe.md
# wb_ctl_pipe

Parametrised writeback-control pipeline that decodes each issued RV32I instruction into writeback controls and carries them through a configurable number of register stages to the writeback port. It generalises the single-stage writeback-select register with valid tracking, stall/flush handling, JALR/illegal decode, x0 write suppression and an in-flight destination scoreboard for hazard detection. It sits between decode/issue and the register-file write port.

## Interface
- STAGES, 2, pipeline depth from issue to writeback output; legal 1..4
- ILLEGAL_TRAP, 1, 1 = unknown opcodes raise `illegal`; 0 = unknown opcodes are silent NOPs
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  `instruction` is valid this cycle
- instruction  in  32  issued RV32I instruction
- stall  in  1  hold every stage
- flush  in  1  kill every in-flight entry and the current input
- query_rs1, query_rs2  in  5  source registers to check against in-flight writes
- out_valid  out  1  last-stage entry is valid
- wb_sel  out  2  00 mem/none, 01 ALU, 10 PC+4
- rd  out  5  destination register
- reg_we  out  1  register-file write enable
- is_load  out  1  entry is a load
- illegal  out  1  entry had an unknown opcode
- hit_rs1, hit_rs2  out  1  query matches a pending write

## Operation
- Decode of `instruction[6:0]`:
  - LUI, AUIPC, OP-IMM, OP: wb_sel 01, we 1
  - JAL, JALR: wb_sel 10, we 1
  - LOAD: wb_sel 00, we 1, is_load 1
  - BRANCH, STORE, FENCE, SYSTEM: wb_sel 00, we 0
  - Any other opcode: wb_sel 00, we 0, illegal = ILLEGAL_TRAP
- wb_sel is never X.
- rd = `instruction[11:7]`. we is forced to 0 when rd == 0, so x0 is never written.
- Each entry holds {valid, wb_sel, rd, we, is_load, illegal}. Stage 0 captures the decoded input; stage i captures stage i-1. The output comes from stage STAGES-1.
- Advance: when stall = 0 and flush = 0, every stage shifts. Stage 0 valid becomes `in_valid`.
- Stall: when stall = 1 and flush = 0, every stage holds. The input is not captured; upstream must hold it.
- Flush: when flush = 1, every valid bit clears on the next edge, regardless of stall or in_valid. Payload fields may keep stale values.
- Output gating: when out_valid = 0, wb_sel, rd, reg_we, is_load and illegal all read 0.
- Scoreboard: hit_rsN = OR over all stages of (valid & we & rd == query_rsN). The result is forced to 0 when query_rsN == 0.
  - Purely combinational from registered state and the query inputs.
  - The current-cycle input is not included.

## Timing
- Reset (rst_n low, asynchronous): all valid bits and payload fields clear. All outputs are 0 immediately, with no clock required.
- Latency: an instruction accepted at edge N appears at the output after edge N+STAGES-1, i.e. it is visible STAGES edges after the cycle it was presented, with zero stalls.
- Each stall cycle adds exactly one cycle of latency. Throughput is one entry per non-stalled cycle.
- Flush asserted in cycle N: out_valid = 0 and hit = 0 from edge N+1 until new entries propagate. The first post-flush instruction can be accepted at edge N+2.
- Simultaneous stall and flush: flush wins.
- Simultaneous in_valid and flush: the input is dropped.
- Reset deasserted mid-stream: the pipeline restarts empty, and nothing in flight is recovered.
- A held output stays stable for the whole duration of a stall.

## Test plan
- Reset: drive rst_n low mid-stream with 3 entries in flight -> all outputs 0 with no clock edge. After release, 0x00000013 (ADDI x0) gives out_valid 1 after STAGES edges, with wb_sel 01 and reg_we 0 (x0 suppressed).
- Decode sweep at STAGES=2:
  - 0x004000EF (JAL x1) -> wb_sel 10, rd 1, we 1
  - 0x00008067 (JALR x0) -> wb_sel 10, we 0
  - 0x0000A103 (LW x2) -> wb_sel 00, we 1, is_load 1
  - 0x00112023 (SW) -> we 0
  - 0xFFFFFFFF -> illegal 1
- Stall: issue ADDI x5 and ADDI x6 back-to-back, then hold stall for 3 cycles -> output frozen on rd 5 for 3 cycles, then rd 6 follows with no loss or duplication.
- Flush: with LUI x7 in stage 0 and JAL x1 in the last stage, assert flush together with stall and in_valid -> next cycle out_valid 0, hit 0, and the input is not captured.
- Scoreboard: with LW x3 in flight, query_rs1 = 3 -> hit_rs1 1. query_rs2 = 0 with x0 pending -> hit_rs2 0. After the entry leaves the last stage -> hit_rs1 0.
- Parameter sweep: for STAGES = 1 and STAGES = 4, measure latency equal to STAGES cycles. Stream 100 random instructions and compare against a reference model.
